wb_regfile: RTL and testbench

- Writeback stage and architectural register file for the 64-bit SEQ Y86 processor.
- Sits directly downstream of the data memory stage. Consumes valE from execute, valM and stat from memory, and dstE/dstM from decode.
- Provides combinational source-register reads (valA/valB) to the decode stage.
- Holds the architectural status and halt latch, plus a retired-instruction counter.

---
 rtl/y86_pkg.sv | 41 ++++
 rtl/reg_array_2r2w.sv | 47 ++++
 rtl/wb_regfile.sv | 69 ++++++
 tb/tb_wb_regfile.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: status codes, register ids and icodes.
// Imported by the writeback stage and its register array.
package y86_pkg;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] REG_RSP  = 4'd4;
    localparam logic [3:0] REG_NONE = 4'hF;

    localparam logic [3:0] I_HALT   = 4'd0;
    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] I_RRMOVQ = 4'd2;
    localparam logic [3:0] I_IRMOVQ = 4'd3;
    localparam logic [3:0] I_RMMOVQ = 4'd4;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_OPQ    = 4'd6;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_PUSHQ  = 4'd10;
    localparam logic [3:0] I_POPQ   = 4'd11;

    // Fold the retiring instruction's status into one of the four legal
    // codes; a halt icode with AOK status still stops the machine.
    function automatic logic [2:0] norm_stat(input logic [3:0] icode,
                                             input logic [2:0] stat_in);
        logic [2:0] s;
        unique case (stat_in)
            STAT_AOK: s = (icode == I_HALT) ? STAT_HLT : STAT_AOK;
            STAT_HLT: s = STAT_HLT;
            STAT_ADR: s = STAT_ADR;
            STAT_INS: s = STAT_INS;
            default:  s = STAT_INS;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/reg_array_2r2w.sv
// 64-bit architectural register storage: two combinational read ports,
// two write ports where port M wins over port E on a shared id.
module reg_array_2r2w
    import y86_pkg::*;
#(
    parameter int          NREG       = 15,
    parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_FFF8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_e,
    input  logic [3:0]  addr_e,
    input  logic [63:0] data_e,
    input  logic        we_m,
    input  logic [3:0]  addr_m,
    input  logic [63:0] data_m,
    input  logic [3:0]  addr_a,
    output logic [63:0] data_a,
    input  logic [3:0]  addr_b,
    output logic [63:0] data_b
);

    logic [63:0] mem [NREG];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (!rst_n) begin
                mem[i] <= (4'(i) == REG_RSP) ? STACK_INIT : 64'd0;
            end else if (we_m && addr_m == 4'(i)) begin
                mem[i] <= data_m;
            end else if (we_e && addr_e == 4'(i)) begin
                mem[i] <= data_e;
            end
        end
    end

    // Ids with no backing register (RNONE) read as zero.
    always_comb begin
        data_a = 64'd0;
        data_b = 64'd0;
        for (int i = 0; i < NREG; i++) begin
            if (addr_a == 4'(i)) data_a = mem[i];
            if (addr_b == 4'(i)) data_b = mem[i];
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// SEQ Y86-64 writeback stage: register file commit, status/halt latch
// and retired-instruction counter.
module wb_regfile
    import y86_pkg::*;
#(
    parameter int          NREG       = 15,
    parameter logic [63:0] STACK_INIT = 64'h0000_0000_0000_FFF8,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_en,
    input  logic [3:0]       icode,
    input  logic [2:0]       stat_in,
    input  logic [3:0]       dstE,
    input  logic [3:0]       dstM,
    input  logic [63:0]      valE,
    input  logic [63:0]      valM,
    input  logic [3:0]       srcA,
    input  logic [3:0]       srcB,
    output logic [63:0]      valA,
    output logic [63:0]      valB,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    logic [2:0] eff_stat;
    logic       live;
    logic       commit;
    logic       fault;

    assign eff_stat = norm_stat(icode, stat_in);
    assign live     = wb_en && !halted;
    assign commit   = live && (eff_stat == STAT_AOK);
    assign fault    = live && (eff_stat != STAT_AOK);

    reg_array_2r2w #(
        .NREG       (NREG),
        .STACK_INIT (STACK_INIT)
    ) u_regs (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_e   (commit && dstE != REG_NONE),
        .addr_e (dstE),
        .data_e (valE),
        .we_m   (commit && dstM != REG_NONE),
        .addr_m (dstM),
        .data_m (valM),
        .addr_a (srcA),
        .data_a (valA),
        .addr_b (srcB),
        .data_b (valB)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat    <= STAT_AOK;
            halted  <= 1'b0;
            retired <= '0;
        end else if (fault) begin
            stat   <= eff_stat;
            halted <= 1'b1;
        end else if (commit) begin
            retired <= retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for the wb_regfile writeback stage.
module tb_wb_regfile;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_en;
    logic [3:0]  icode;
    logic [2:0]  stat_in;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    wb_regfile dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wb_en   (wb_en),
        .icode   (icode),
        .stat_in (stat_in),
        .dstE    (dstE),
        .dstM    (dstM),
        .valE    (valE),
        .valM    (valM),
        .srcA    (srcA),
        .srcB    (srcB),
        .valA    (valA),
        .valB    (valB),
        .stat    (stat),
        .halted  (halted),
        .retired (retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_en   = 1'b0;
        icode   = I_NOP;
        stat_in = STAT_AOK;
        dstE    = REG_NONE;
        dstM    = REG_NONE;
        valE    = 64'd0;
        valM    = 64'd0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        srcA = 4'd4;
        srcB = 4'd0;
        #1;
        checks++;
        if (valA !== 64'hFFF8) begin
            errors++;
            $display("FAIL reset_rsp: got %h want %h", valA, 64'hFFF8);
        end
        checks++;
        if (valB !== 64'd0) begin
            errors++;
            $display("FAIL reset_r0: got %h want 0", valB);
        end
        checks++;
        if (stat !== STAT_AOK) begin
            errors++;
            $display("FAIL reset_stat: got %0d want 1", stat);
        end
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_halted: got %b want 0", halted);
        end
        checks++;
        if (retired !== 32'd0) begin
            errors++;
            $display("FAIL reset_retired: got %0d want 0", retired);
        end
    endtask

    task automatic test_single_write();
        wb_en   = 1'b1;
        icode   = I_IRMOVQ;
        stat_in = STAT_AOK;
        dstE    = 4'd2;
        valE    = 64'h1234;
        dstM    = REG_NONE;
        srcA    = 4'd2;
        #1;
        checks++;
        if (valA !== 64'd0) begin
            errors++;
            $display("FAIL write_prebypass: got %h want 0", valA);
        end
        step();
        idle();
        #1;
        checks++;
        if (valA !== 64'h1234) begin
            errors++;
            $display("FAIL write_r2: got %h want 1234", valA);
        end
        checks++;
        if (retired !== 32'd1) begin
            errors++;
            $display("FAIL write_retired: got %0d want 1", retired);
        end
    endtask

    task automatic test_collision();
        wb_en   = 1'b1;
        icode   = I_POPQ;
        dstE    = 4'd4;
        dstM    = 4'd4;
        valE    = 64'hAAAA;
        valM    = 64'hBBBB;
        srcA    = 4'd4;
        step();
        idle();
        #1;
        checks++;
        if (valA !== 64'hBBBB) begin
            errors++;
            $display("FAIL collision_r4: got %h want BBBB", valA);
        end
    endtask

    task automatic test_dual_write();
        wb_en   = 1'b1;
        icode   = I_POPQ;
        dstE    = 4'd5;
        dstM    = 4'd14;
        valE    = 64'h11;
        valM    = 64'hDEAD_BEEF_0000_0022;
        srcA    = 4'd5;
        srcB    = 4'd14;
        step();
        idle();
        #1;
        checks++;
        if (valA !== 64'h11) begin
            errors++;
            $display("FAIL dual_r5: got %h want 11", valA);
        end
        checks++;
        if (valB !== 64'hDEAD_BEEF_0000_0022) begin
            errors++;
            $display("FAIL dual_r14: got %h want deadbeef00000022", valB);
        end
        checks++;
        if (retired !== 32'd3) begin
            errors++;
            $display("FAIL dual_retired: got %0d want 3", retired);
        end
    endtask

    task automatic test_stall_rnone();
        idle();
        dstE = 4'd3;
        valE = 64'h77;
        srcA = 4'd3;
        step();
        #1;
        checks++;
        if (valA !== 64'd0) begin
            errors++;
            $display("FAIL stall_r3: got %h want 0", valA);
        end
        checks++;
        if (retired !== 32'd3) begin
            errors++;
            $display("FAIL stall_retired: got %0d want 3", retired);
        end
        srcA = 4'd15;
        srcB = 4'd4;
        #1;
        checks++;
        if (valA !== 64'd0) begin
            errors++;
            $display("FAIL rnone_read: got %h want 0", valA);
        end
        checks++;
        if (valB !== 64'hBBBB) begin
            errors++;
            $display("FAIL rnone_r4: got %h want BBBB", valB);
        end
    endtask

    task automatic test_error_freeze();
        wb_en   = 1'b1;
        icode   = I_MRMOVQ;
        stat_in = STAT_ADR;
        dstE    = 4'd1;
        valE    = 64'd5;
        srcA    = 4'd1;
        step();
        checks++;
        if (valA !== 64'd0) begin
            errors++;
            $display("FAIL fault_r1: got %h want 0", valA);
        end
        checks++;
        if (stat !== STAT_ADR || halted !== 1'b1) begin
            errors++;
            $display("FAIL fault_stat: got %0d/%b want 3/1", stat, halted);
        end
        checks++;
        if (retired !== 32'd3) begin
            errors++;
            $display("FAIL fault_retired: got %0d want 3", retired);
        end
        stat_in = STAT_AOK;
        icode   = I_IRMOVQ;
        valE    = 64'd9;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (valA !== 64'd0 || retired !== 32'd3) begin
            errors++;
            $display("FAIL frozen: got r1=%h ret=%0d want 0/3", valA, retired);
        end
        checks++;
        if (stat !== STAT_ADR || halted !== 1'b1) begin
            errors++;
            $display("FAIL frozen_stat: got %0d/%b want 3/1", stat, halted);
        end
    endtask

    task automatic test_reset_mid_halt();
        wb_en   = 1'b1;
        icode   = I_IRMOVQ;
        stat_in = STAT_AOK;
        dstE    = 4'd4;
        valE    = 64'h55;
        rst_n   = 1'b0;
        step();
        rst_n = 1'b1;
        idle();
        srcA = 4'd4;
        srcB = 4'd2;
        #1;
        checks++;
        if (stat !== STAT_AOK || halted !== 1'b0) begin
            errors++;
            $display("FAIL rsthalt_stat: got %0d/%b want 1/0", stat, halted);
        end
        checks++;
        if (valA !== 64'hFFF8 || valB !== 64'd0) begin
            errors++;
            $display("FAIL rsthalt_regs: got %h/%h want fff8/0", valA, valB);
        end
        checks++;
        if (retired !== 32'd0) begin
            errors++;
            $display("FAIL rsthalt_retired: got %0d want 0", retired);
        end
    endtask

    task automatic test_icode_halt();
        wb_en   = 1'b1;
        icode   = I_HALT;
        stat_in = STAT_AOK;
        dstE    = 4'd2;
        valE    = 64'h3;
        srcA    = 4'd2;
        step();
        idle();
        checks++;
        if (stat !== STAT_HLT || halted !== 1'b1) begin
            errors++;
            $display("FAIL icode_halt: got %0d/%b want 2/1", stat, halted);
        end
        checks++;
        if (valA !== 64'd0 || retired !== 32'd0) begin
            errors++;
            $display("FAIL icode_halt_regs: got %h/%0d want 0/0", valA, retired);
        end
    endtask

    task automatic test_bad_stat();
        do_reset();
        wb_en   = 1'b1;
        icode   = I_OPQ;
        stat_in = 3'd6;
        dstE    = 4'd7;
        valE    = 64'h99;
        srcA    = 4'd7;
        step();
        idle();
        checks++;
        if (stat !== STAT_INS || halted !== 1'b1) begin
            errors++;
            $display("FAIL bad_stat: got %0d/%b want 4/1", stat, halted);
        end
        checks++;
        if (valA !== 64'd0) begin
            errors++;
            $display("FAIL bad_stat_r7: got %h want 0", valA);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wb_en   = 1'b1;
        icode   = I_IRMOVQ;
        stat_in = STAT_AOK;
        dstM    = REG_NONE;
        for (int i = 0; i < 4; i++) begin
            dstE = 4'(8 + i);
            valE = 64'(100 + i);
            step();
        end
        idle();
        srcA = 4'd8;
        srcB = 4'd11;
        #1;
        checks++;
        if (valA !== 64'd100 || valB !== 64'd103) begin
            errors++;
            $display("FAIL b2b_regs: got %0d/%0d want 100/103", valA, valB);
        end
        checks++;
        if (retired !== 32'd4) begin
            errors++;
            $display("FAIL b2b_retired: got %0d want 4", retired);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        srcA  = REG_NONE;
        srcB  = REG_NONE;
        idle();
        #2;
        test_reset();
        test_single_write();
        test_collision();
        test_dual_write();
        test_stall_rnone();
        test_error_freeze();
        test_reset_mid_halt();
        test_icode_halt();
        test_bad_stat();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
